fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_arbiter_if.sv | 55 +++++
 rtl/fb_arb_prio.sv | 46 ++++
 rtl/fb_arbiter.sv | 139 +++++++++++++
 tb/tb_fb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter and the framebuffer itself.
// State encoding, default pixel width and screen geometry.
package fb_pkg;

    localparam int FB_WIDTH = 32;
    localparam int FB_VER_X = 640;
    localparam int FB_HOR_Y = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic logic in_range(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int                 vx,
        input int                 hy
    );
        return (int'({22'd0, x}) < vx) && (int'({22'd0, y}) < hy);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Client and framebuffer signals of the arbiter.
// master = arbiter side, slave = clients plus framebuffer.
interface fb_arbiter_if #(
    parameter int WIDTH = fb_pkg::FB_WIDTH
);
    import fb_pkg::*;

    logic               rd_req;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_ack;
    logic               rd_valid;
    logic [WIDTH-1:0]   rd_rgb;

    logic               wr_valid;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic [WIDTH-1:0]   wr_rgb;
    logic               wr_ready;
    logic               wr_done;

    logic               fb_do_read;
    logic               fb_do_write;
    logic [COORD_W-1:0] fb_pix_x;
    logic [COORD_W-1:0] fb_pix_y;
    logic [WIDTH-1:0]   fb_write_rgb;
    logic               fb_busy;
    logic               fb_done;
    logic [WIDTH-1:0]   fb_read_rgb;

    logic               timeout_err;

    modport master (
        input  rd_req, rd_x, rd_y,
        input  wr_valid, wr_x, wr_y, wr_rgb,
        input  fb_busy, fb_done, fb_read_rgb,
        output rd_ack, rd_valid, rd_rgb,
        output wr_ready, wr_done,
        output fb_do_read, fb_do_write,
        output fb_pix_x, fb_pix_y, fb_write_rgb,
        output timeout_err
    );

    modport slave (
        output rd_req, rd_x, rd_y,
        output wr_valid, wr_x, wr_y, wr_rgb,
        output fb_busy, fb_done, fb_read_rgb,
        input  rd_ack, rd_valid, rd_rgb,
        input  wr_ready, wr_done,
        input  fb_do_read, fb_do_write,
        input  fb_pix_x, fb_pix_y, fb_write_rgb,
        input  timeout_err
    );

endinterface

// File: rtl/fb_arb_prio.sv
// Read-over-write grant selection with a bounded read streak
// so a pending write cannot be starved by continuous scanout.
module fb_arb_prio #(
    parameter int MAX_RD_STREAK = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rd_req,
    input  logic wr_valid,
    output logic gnt_rd,
    output logic gnt_wr
);

    localparam int SW = (MAX_RD_STREAK > 0) ? $clog2(MAX_RD_STREAK + 1) : 1;

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          starve;

    assign starve = (streak_q == SW'(MAX_RD_STREAK));

    always_comb begin
        gnt_wr   = en && wr_valid && (!rd_req || starve);
        gnt_rd   = en && rd_req && !gnt_wr;
        streak_d = streak_q;
        if (gnt_wr) begin
            streak_d = '0;
        end else if (gnt_rd) begin
            if (!wr_valid) begin
                streak_d = '0;
            end else if (!starve) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Arbitrates scanout reads and compute writes onto one framebuffer port,
// with out-of-range short-circuit and a bounded wait for completion.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int WIDTH         = FB_WIDTH,
    parameter int ver_x         = FB_VER_X,
    parameter int hor_y         = FB_HOR_Y,
    parameter int MAX_RD_STREAK = 8,
    parameter int TIMEOUT       = 1024
) (
    input logic          clk,
    input logic          rst,
    fb_arbiter_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               op_rd_q;
    logic               rd_valid_q;
    logic [WIDTH-1:0]   rd_rgb_q;
    logic               wr_done_q;
    logic               do_rd_q;
    logic               do_wr_q;
    logic [COORD_W-1:0] pix_x_q;
    logic [COORD_W-1:0] pix_y_q;
    logic [WIDTH-1:0]   wdata_q;
    logic               terr_q;

    logic               en;
    logic               gnt_rd;
    logic               gnt_wr;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic               sel_ok;

    // Grants are gated by reset so none can land in a reset cycle.
    assign en = rst && (state_q == IDLE) && !bus.fb_busy;

    fb_arb_prio #(
        .MAX_RD_STREAK (MAX_RD_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rd_req   (bus.rd_req),
        .wr_valid (bus.wr_valid),
        .gnt_rd   (gnt_rd),
        .gnt_wr   (gnt_wr)
    );

    assign sel_x  = gnt_rd ? bus.rd_x : bus.wr_x;
    assign sel_y  = gnt_rd ? bus.rd_y : bus.wr_y;
    assign sel_ok = in_range(sel_x, sel_y, ver_x, hor_y);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_rd_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_rgb_q   <= '0;
            wr_done_q  <= 1'b0;
            do_rd_q    <= 1'b0;
            do_wr_q    <= 1'b0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            wdata_q    <= '0;
            terr_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            do_rd_q    <= 1'b0;
            do_wr_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_rd || gnt_wr) begin
                        op_rd_q <= gnt_rd;
                        if (sel_ok) begin
                            pix_x_q <= sel_x;
                            pix_y_q <= sel_y;
                            if (gnt_wr) begin
                                wdata_q <= bus.wr_rgb;
                            end
                            do_rd_q <= gnt_rd;
                            do_wr_q <= gnt_wr;
                            state_q <= ISSUE;
                        end else begin
                            // Off-screen: complete at once, nothing reaches the buffer.
                            rd_valid_q <= gnt_rd;
                            wr_done_q  <= gnt_wr;
                            if (gnt_rd) begin
                                rd_rgb_q <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.fb_done) begin
                        if (op_rd_q) begin
                            rd_rgb_q   <= bus.fb_read_rgb;
                            rd_valid_q <= 1'b1;
                        end else begin
                            wr_done_q  <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        terr_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rd_ack       = gnt_rd;
    assign bus.wr_ready     = gnt_wr;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_rgb       = rd_rgb_q;
    assign bus.wr_done      = wr_done_q;
    assign bus.fb_do_read   = do_rd_q;
    assign bus.fb_do_write  = do_wr_q;
    assign bus.fb_pix_x     = pix_x_q;
    assign bus.fb_pix_y     = pix_y_q;
    assign bus.fb_write_rgb = wdata_q;
    assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_fb_arbiter;

    localparam int VX  = 640;
    localparam int HY  = 480;
    localparam int MAX = 8;
    localparam int TMO = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_arbiter_if #(.WIDTH(32)) bus();

    fb_arbiter #(
        .WIDTH         (32),
        .ver_x         (VX),
        .hor_y         (HY),
        .MAX_RD_STREAK (MAX),
        .TIMEOUT       (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int nvec = 0;
    int nerr = 0;
    bit armed = 0;
    byte gq[$];

    // Model: one transaction in flight at most.
    bit          m_busy, m_issued, m_op_rd;
    int          m_waited, m_streak;
    logic        e_rd_ack, e_wr_ready, l_rd_ack, l_wr_ready;
    logic        e_rd_valid, e_wr_done, e_do_rd, e_do_wr, e_terr;
    logic [31:0] e_rd_rgb, e_wrgb;
    logic [9:0]  e_px, e_py;

    function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_grant();
        e_rd_ack   = 1'b0;
        e_wr_ready = 1'b0;
        if (rst && !m_busy && !bus.fb_busy) begin
            if (bus.wr_valid && (!bus.rd_req || m_streak == MAX))
                e_wr_ready = 1'b1;
            else if (bus.rd_req)
                e_rd_ack = 1'b1;
        end
    endfunction

    function automatic void model_step();
        int x, y;
        if (!rst) begin
            m_busy = 0; m_issued = 0; m_streak = 0; m_waited = 0;
            e_rd_valid = 0; e_wr_done = 0; e_do_rd = 0; e_do_wr = 0;
            e_terr = 0; e_rd_rgb = 0; e_wrgb = 0; e_px = 0; e_py = 0;
            return;
        end
        e_rd_valid = 0; e_wr_done = 0; e_do_rd = 0; e_do_wr = 0;
        if (!m_busy) begin
            if (e_rd_ack || e_wr_ready) begin
                x = e_rd_ack ? int'(bus.rd_x) : int'(bus.wr_x);
                y = e_rd_ack ? int'(bus.rd_y) : int'(bus.wr_y);
                if (e_wr_ready || !bus.wr_valid) m_streak = 0;
                else if (m_streak < MAX) m_streak++;
                if (x < VX && y < HY) begin
                    e_px = 10'(x);
                    e_py = 10'(y);
                    if (e_wr_ready) e_wrgb = bus.wr_rgb;
                    e_do_rd = e_rd_ack;
                    e_do_wr = e_wr_ready;
                    m_busy = 1; m_issued = 0; m_op_rd = e_rd_ack;
                end else if (e_rd_ack) begin
                    e_rd_valid = 1; e_rd_rgb = 0;
                end else begin
                    e_wr_done = 1;
                end
            end
        end else if (!m_issued) begin
            m_issued = 1;
            m_waited = 0;
        end else begin
            m_waited++;
            if (bus.fb_done) begin
                if (m_op_rd) begin e_rd_valid = 1; e_rd_rgb = bus.fb_read_rgb; end
                else e_wr_done = 1;
                m_busy = 0;
            end else if (m_waited == TMO) begin
                e_terr = 1;
                m_busy = 0;
            end
        end
    endfunction

    function automatic void check_all();
        cmp("rd_ack", 32'(bus.rd_ack), 32'(e_rd_ack));
        cmp("wr_ready", 32'(bus.wr_ready), 32'(e_wr_ready));
        cmp("rd_valid", 32'(bus.rd_valid), 32'(e_rd_valid));
        cmp("rd_rgb", bus.rd_rgb, e_rd_rgb);
        cmp("wr_done", 32'(bus.wr_done), 32'(e_wr_done));
        cmp("fb_do_read", 32'(bus.fb_do_read), 32'(e_do_rd));
        cmp("fb_do_write", 32'(bus.fb_do_write), 32'(e_do_wr));
        cmp("fb_pix_x", 32'(bus.fb_pix_x), 32'(e_px));
        cmp("fb_pix_y", 32'(bus.fb_pix_y), 32'(e_py));
        cmp("fb_write_rgb", bus.fb_write_rgb, e_wrgb);
        cmp("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
    endfunction

    // Inputs are set after a falling edge; step checks, advances the model
    // and returns at the next falling edge.
    task automatic step();
        #1;
        model_grant();
        if (armed) check_all();
        if (bus.rd_ack === 1'b1) gq.push_back("R");
        if (bus.wr_ready === 1'b1) gq.push_back("W");
        l_rd_ack   = e_rd_ack;
        l_wr_ready = e_wr_ready;
        model_step();
        if (!rst) armed = 1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rd_req = 0; bus.rd_x = 0; bus.rd_y = 0;
        bus.wr_valid = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_rgb = 0;
        bus.fb_busy = 0; bus.fb_done = 0; bus.fb_read_rgb = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
    endtask

    function automatic logic [9:0] rnd_coord(int lim);
        if ($urandom_range(9) == 0) return 10'(lim + int'($urandom_range(1023 - lim)));
        return 10'($urandom_range(lim - 1));
    endfunction

    initial begin
        int n;
        string exp_seq;
        rst = 0;
        idle_inputs();
        @(negedge clk);
        step();
        step();
        rst = 1;
        cmp("reset_rd_rgb", bus.rd_rgb, 32'h0);
        cmp("reset_timeout", 32'(bus.timeout_err), 32'h0);

        // Read at (10,20), completion five cycles after the strobe.
        bus.rd_req = 1; bus.rd_x = 10; bus.rd_y = 20;
        #1 cmp("rd_ack_T", 32'(bus.rd_ack), 32'h1);
        step();
        cmp("rd_strobe", 32'(bus.fb_do_read), 32'h1);
        cmp("rd_pix_x", 32'(bus.fb_pix_x), 32'd10);
        cmp("rd_pix_y", 32'(bus.fb_pix_y), 32'd20);
        bus.rd_req = 0;
        repeat (5) step();
        bus.fb_done = 1; bus.fb_read_rgb = 32'h00112233;
        step();
        bus.fb_done = 0;
        cmp("rd_valid_D1", 32'(bus.rd_valid), 32'h1);
        cmp("rd_rgb_D1", bus.rd_rgb, 32'h00112233);
        step();

        // Write at (100,200).
        do_reset();
        bus.wr_valid = 1; bus.wr_x = 100; bus.wr_y = 200; bus.wr_rgb = 32'h00BBCCDD;
        #1 cmp("wr_ready_T", 32'(bus.wr_ready), 32'h1);
        step();
        cmp("wr_strobe", 32'(bus.fb_do_write), 32'h1);
        cmp("wr_data", bus.fb_write_rgb, 32'h00BBCCDD);
        bus.wr_valid = 0;
        step();
        cmp("wr_strobe_once", 32'(bus.fb_do_write), 32'h0);
        bus.fb_done = 1;
        step();
        bus.fb_done = 0;
        cmp("wr_done_D1", 32'(bus.wr_done), 32'h1);
        step();

        // Starvation: both held, eight reads then one write.
        do_reset();
        bus.rd_req = 1; bus.rd_x = 1; bus.rd_y = 2;
        bus.wr_valid = 1; bus.wr_x = 3; bus.wr_y = 4; bus.wr_rgb = 32'h55;
        bus.fb_done = 1;
        gq.delete();
        repeat (40) step();
        exp_seq = "RRRRRRRRWR";
        cmp("starve_count", 32'(gq.size() >= 10), 32'h1);
        for (int i = 0; i < 10 && i < gq.size(); i++)
            cmp("starve_order", 32'(gq[i]), 32'(exp_seq[i]));
        idle_inputs();
        step();

        // Off-screen read then write.
        do_reset();
        bus.rd_req = 1; bus.rd_x = 640; bus.rd_y = 0;
        #1 cmp("rng_rd_ack", 32'(bus.rd_ack), 32'h1);
        step();
        cmp("rng_rd_valid", 32'(bus.rd_valid), 32'h1);
        cmp("rng_rd_rgb", bus.rd_rgb, 32'h0);
        cmp("rng_no_rd", 32'(bus.fb_do_read), 32'h0);
        bus.rd_req = 0;
        bus.wr_valid = 1; bus.wr_x = 0; bus.wr_y = 480; bus.wr_rgb = 32'h77;
        #1 cmp("rng_wr_ready", 32'(bus.wr_ready), 32'h1);
        step();
        cmp("rng_wr_done", 32'(bus.wr_done), 32'h1);
        cmp("rng_no_wr", 32'(bus.fb_do_write), 32'h0);
        bus.wr_valid = 0;
        step();

        // Timeout: fb_done never comes.
        do_reset();
        bus.rd_req = 1; bus.rd_x = 5; bus.rd_y = 5;
        #1 cmp("to_ack", 32'(bus.rd_ack), 32'h1);
        step();
        bus.rd_req = 0;
        n = 1;
        while (bus.timeout_err !== 1'b1 && n < 1100) begin
            step();
            n++;
        end
        cmp("to_cycles", 32'(n), 32'd1026);
        bus.rd_req = 1;
        #1 cmp("to_regrant", 32'(bus.rd_ack), 32'h1);
        step();
        bus.rd_req = 0; bus.fb_done = 1;
        repeat (3) step();
        bus.fb_done = 0;

        // Reset while waiting, completion arrives afterwards.
        do_reset();
        bus.rd_req = 1; bus.rd_x = 7; bus.rd_y = 9;
        step();
        bus.rd_req = 0;
        step();
        rst = 0; bus.rd_req = 1;
        #1 cmp("rst_no_ack", 32'(bus.rd_ack), 32'h0);
        step();
        cmp("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        cmp("rst_pix_x", 32'(bus.fb_pix_x), 32'h0);
        cmp("rst_pix_y", 32'(bus.fb_pix_y), 32'h0);
        cmp("rst_do_read", 32'(bus.fb_do_read), 32'h0);
        rst = 1; bus.rd_req = 0; bus.fb_done = 1; bus.fb_read_rgb = 32'hDEAD;
        step();
        cmp("rst_no_done", 32'(bus.rd_valid), 32'h0);
        bus.fb_done = 0;
        step();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(399) != 0);
            if (bus.rd_req && l_rd_ack) bus.rd_req = 0;
            if (bus.wr_valid && l_wr_ready) bus.wr_valid = 0;
            if (!bus.rd_req && $urandom_range(2) == 0) begin
                bus.rd_req = 1;
                bus.rd_x = rnd_coord(VX);
                bus.rd_y = rnd_coord(HY);
            end
            if (!bus.wr_valid && $urandom_range(2) == 0) begin
                bus.wr_valid = 1;
                bus.wr_x = rnd_coord(VX);
                bus.wr_y = rnd_coord(HY);
                bus.wr_rgb = $urandom;
            end
            bus.fb_busy = ($urandom_range(4) == 0);
            bus.fb_done = ($urandom_range(2) == 0);
            bus.fb_read_rgb = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
